// File: rtl/uart_cmd_processor.sv
// uart_cmd_processor: turns a 2-byte UART request into a DHT11 read and a 2-byte UART response.
// Every output is registered. The FSM computes the next value of each register and always_ff stores it.
module uart_cmd_processor #(
    parameter int BYTE_TIMEOUT_CLKS   = 5_000_000,
    parameter int SENSOR_TIMEOUT_CLKS = 50_000_000,
    parameter int NUM_SENSORS         = 32
) (
    input  logic        i_Clock,
    input  logic        i_Rst_n,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    output logic        o_Tx_DV,
    output logic [7:0]  o_Tx_Byte,
    input  logic        i_Tx_Active,
    input  logic        i_Tx_Done,
    output logic        o_Sensor_Req,
    output logic [4:0]  o_Sensor_Addr,
    input  logic        i_Sensor_Valid,
    input  logic        i_Sensor_Err,
    input  logic [39:0] i_Sensor_Data,
    output logic        o_Busy
);
    typedef enum logic [2:0] {IDLE, GET_ADDR, CHECK, SENSOR_WAIT, SEND0, WAIT0, SEND1, WAIT1} state_t;

    state_t      state, state_d;
    logic [7:0]  cmd, cmd_d, addr, addr_d, resp0, resp0_d, resp1, resp1_d, tx_byte_d;
    logic [31:0] cnt, cnt_d;
    logic        tx_dv_d, req_d;
    logic [4:0]  sensor_addr_d;
    logic [7:0]  sum;
    logic        sensor_bad;

    assign sum        = i_Sensor_Data[39:32] + i_Sensor_Data[31:24] + i_Sensor_Data[23:16] + i_Sensor_Data[15:8];
    assign sensor_bad = i_Sensor_Err || (sum != i_Sensor_Data[7:0]);

    always_comb begin
        state_d       = state;
        cmd_d         = cmd;
        addr_d        = addr;
        resp0_d       = resp0;
        resp1_d       = resp1;
        cnt_d         = cnt + 32'd1;
        tx_dv_d       = 1'b0;
        tx_byte_d     = o_Tx_Byte;
        req_d         = 1'b0;
        sensor_addr_d = o_Sensor_Addr;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (i_Rx_DV) begin
                    cmd_d   = i_Rx_Byte;
                    state_d = GET_ADDR;
                end
            end
            GET_ADDR: begin
                if (i_Rx_DV) begin
                    addr_d  = i_Rx_Byte;
                    state_d = CHECK;
                end else if (cnt == 32'(BYTE_TIMEOUT_CLKS - 1)) begin
                    state_d = IDLE;
                end
            end
            CHECK: begin
                cnt_d = '0;
                if (cmd > 8'h02) begin
                    {resp0_d, resp1_d} = {8'hEF, 8'h00};
                    state_d            = SEND0;
                end else if (32'(addr) >= 32'(NUM_SENSORS)) begin
                    {resp0_d, resp1_d} = {8'hDF, 8'h00};
                    state_d            = SEND0;
                end else begin
                    req_d         = 1'b1;
                    sensor_addr_d = addr[4:0];
                    state_d       = SENSOR_WAIT;
                end
            end
            SENSOR_WAIT: begin
                // a silent sensor is reported exactly like a failed read
                if (i_Sensor_Valid) begin
                    {resp0_d, resp1_d} = sensor_bad     ? {8'h1F, 8'h00} :
                                         cmd == 8'h00   ? {8'h07, 8'h00} :
                                         cmd == 8'h01   ? {8'h09, i_Sensor_Data[23:16]} :
                                                          {8'h08, i_Sensor_Data[39:32]};
                    state_d = SEND0;
                end else if (cnt == 32'(SENSOR_TIMEOUT_CLKS - 1)) begin
                    {resp0_d, resp1_d} = {8'h1F, 8'h00};
                    state_d            = SEND0;
                end
            end
            SEND0: begin
                if (!i_Tx_Active) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = resp0;
                    state_d   = WAIT0;
                end
            end
            WAIT0: state_d = i_Tx_Done ? SEND1 : WAIT0;
            SEND1: begin
                if (!i_Tx_Active) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = resp1;
                    state_d   = WAIT1;
                end
            end
            WAIT1: state_d = i_Tx_Done ? IDLE : WAIT1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state         <= IDLE;
            cmd           <= '0;
            addr          <= '0;
            resp0         <= '0;
            resp1         <= '0;
            cnt           <= '0;
            o_Tx_DV       <= 1'b0;
            o_Tx_Byte     <= '0;
            o_Sensor_Req  <= 1'b0;
            o_Sensor_Addr <= '0;
            o_Busy        <= 1'b0;
        end else begin
            state         <= state_d;
            cmd           <= cmd_d;
            addr          <= addr_d;
            resp0         <= resp0_d;
            resp1         <= resp1_d;
            cnt           <= cnt_d;
            o_Tx_DV       <= tx_dv_d;
            o_Tx_Byte     <= tx_byte_d;
            o_Sensor_Req  <= req_d;
            o_Sensor_Addr <= sensor_addr_d;
            o_Busy        <= (state_d != IDLE);
        end
    end
endmodule

// File: tb/tb_uart_cmd_processor.sv
// tb_uart_cmd_processor: directed vector table plus hand sequences for timeouts, TX back-pressure and reset.
module tb_uart_cmd_processor;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        rx_dv = 1'b0, tx_hold = 1'b0, tx_done = 1'b0, model_active = 1'b0;
    logic [7:0]  rx_byte = '0, tx_cur = '0;
    logic        tx_dv, sensor_req, busy;
    logic [7:0]  tx_byte;
    logic [4:0]  sensor_addr;
    logic        sensor_valid = 1'b0, sensor_err = 1'b0;
    logic [39:0] sensor_data = '0;
    int          tx_left = 0, req_cnt = 0, stab_err = 0;
    int          passed = 0, total = 0;
    logic [7:0]  txq[$];

    always #5 clk = ~clk;

    uart_cmd_processor #(.BYTE_TIMEOUT_CLKS(100), .SENSOR_TIMEOUT_CLKS(200), .NUM_SENSORS(32)) dut (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
        .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte), .i_Tx_Active(model_active | tx_hold), .i_Tx_Done(tx_done),
        .o_Sensor_Req(sensor_req), .o_Sensor_Addr(sensor_addr), .i_Sensor_Valid(sensor_valid),
        .i_Sensor_Err(sensor_err), .i_Sensor_Data(sensor_data), .o_Busy(busy)
    );

    // uart_tx stand-in: busy for a few cycles per byte, then a one-cycle Done
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_active <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (tx_dv) begin
                model_active <= 1'b1;
                tx_left      <= 5;
                tx_cur       <= tx_byte;
                txq.push_back(tx_byte);
            end else if (model_active) begin
                if (tx_byte != tx_cur) stab_err <= stab_err + 1;
                if (tx_left == 0) begin
                    model_active <= 1'b0;
                    tx_done      <= 1'b1;
                end else tx_left <= tx_left - 1;
            end
            if (sensor_req) req_cnt <= req_cnt + 1;
        end
    end

    typedef struct {
        logic [7:0]  cmd, addr;
        bit          err;
        logic [39:0] data;
        int          exp_req;
        logic [7:0]  b0, b1;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_dv = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sensor_req) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int n, input int budget, output bit ok);
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (txq.size() >= n && !busy) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic pulse_valid(input bit err, input logic [39:0] data);
        @(negedge clk);
        sensor_valid = 1'b1;
        sensor_err = err;
        sensor_data = data;
        @(negedge clk);
        sensor_valid = 1'b0;
        sensor_err = 1'b0;
    endtask

    task automatic chk_resp(input string name, input logic [7:0] b0, input logic [7:0] b1);
        chk({name, "_ntx"}, 64'(txq.size()), 64'd2);
        chk({name, "_b0"}, txq.size() > 0 ? txq[0] : 8'hxx, b0);
        chk({name, "_b1"}, txq.size() > 1 ? txq[1] : 8'hxx, b1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int r0;
        bit ok;
        r0 = req_cnt;
        txq.delete();
        send_byte(v.cmd);
        send_byte(v.addr);
        if (v.exp_req != 0) begin
            wait_req(ok);
            chk({name, "_req_seen"}, 64'(ok), 64'd1);
            chk({name, "_sensor_addr"}, 64'(sensor_addr), 64'(v.addr[4:0]));
            repeat (3) @(negedge clk);
            pulse_valid(v.err, v.data);
        end
        wait_idle(2, 300, ok);
        chk({name, "_done"}, 64'(ok), 64'd1);
        chk_resp(name, v.b0, v.b1);
        chk({name, "_req_count"}, 64'(req_cnt - r0), 64'(v.exp_req));
    endtask

    initial begin
        bit ok;
        int r0;
        vecs[0] = '{8'h01, 8'h03, 1'b0, 40'h2D00190046, 1, 8'h09, 8'h19};
        vecs[1] = '{8'h02, 8'h00, 1'b0, 40'h2D00190047, 1, 8'h1F, 8'h00};
        vecs[2] = '{8'h05, 8'h40, 1'b0, 40'h0,          0, 8'hEF, 8'h00};
        vecs[3] = '{8'h00, 8'h20, 1'b0, 40'h0,          0, 8'hDF, 8'h00};
        vecs[4] = '{8'h02, 8'h1F, 1'b0, 40'h2D00190046, 1, 8'h08, 8'h2D};
        vecs[5] = '{8'h00, 8'h05, 1'b1, 40'h2D00190046, 1, 8'h1F, 8'h00};
        vecs[6] = '{8'h03, 8'h00, 1'b0, 40'h0,          0, 8'hEF, 8'h00};
        vecs[7] = '{8'h01, 8'h07, 1'b0, 40'h8090100525, 1, 8'h09, 8'h10};

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tx_dv", 64'(tx_dv), 64'd0);
        chk("rst_tx_byte", 64'(tx_byte), 64'd0);
        chk("rst_req", 64'(sensor_req), 64'd0);
        chk("rst_addr", 64'(sensor_addr), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // first byte only: abandoned after the inter-byte timeout
        txq.delete();
        send_byte(8'h00);
        chk("bto_busy_after_cmd", 64'(busy), 64'd1);
        repeat (90) @(negedge clk);
        chk("bto_busy_before_timeout", 64'(busy), 64'd1);
        repeat (20) @(negedge clk);
        chk("bto_idle_after_timeout", 64'(busy), 64'd0);
        chk("bto_no_tx", 64'(txq.size()), 64'd0);
        send_byte(8'h00);
        send_byte(8'h01);
        wait_req(ok);
        chk("bto_req_seen", 64'(ok), 64'd1);
        @(negedge clk);
        sensor_valid = 1'b1;
        sensor_data = 40'h2D00190046;
        @(negedge clk);
        sensor_valid = 1'b0;
        chk("lat_sensor_c1", 64'(tx_dv), 64'd0);
        @(negedge clk);
        chk("lat_sensor_c2", 64'(tx_dv), 64'd1);
        wait_idle(2, 100, ok);
        chk("bto_next_done", 64'(ok), 64'd1);
        chk_resp("bto_next", 8'h07, 8'h00);

        // silent sensor, extra Rx bytes during the wait are dropped
        txq.delete();
        r0 = req_cnt;
        send_byte(8'h01);
        send_byte(8'h02);
        wait_req(ok);
        chk("sto_req_seen", 64'(ok), 64'd1);
        send_byte(8'h00);
        send_byte(8'h05);
        chk("sto_busy_in_wait", 64'(busy), 64'd1);
        wait_idle(2, 400, ok);
        chk("sto_done", 64'(ok), 64'd1);
        chk_resp("sto", 8'h1F, 8'h00);
        chk("sto_req_count", 64'(req_cnt - r0), 64'd1);
        pulse_valid(1'b0, 40'h2D00190046);
        repeat (5) @(negedge clk);
        chk("stray_valid_busy", 64'(busy), 64'd0);
        chk("stray_valid_no_tx", 64'(txq.size()), 64'd2);

        // invalid request latency from CHECK with TX idle
        txq.delete();
        send_byte(8'h07);
        send_byte(8'h00);
        @(negedge clk);
        chk("lat_check_c1", 64'(tx_dv), 64'd0);
        @(negedge clk);
        chk("lat_check_c2", 64'(tx_dv), 64'd1);
        chk("lat_check_byte", 64'(tx_byte), 64'hEF);
        wait_idle(2, 100, ok);
        chk_resp("lat_check", 8'hEF, 8'h00);

        // uart_tx busy: first byte waits until Active falls
        txq.delete();
        tx_hold = 1'b1;
        send_byte(8'h05);
        send_byte(8'h00);
        repeat (50) @(negedge clk);
        chk("hold_no_tx", 64'(txq.size()), 64'd0);
        chk("hold_busy", 64'(busy), 64'd1);
        tx_hold = 1'b0;
        wait_idle(2, 100, ok);
        chk("hold_done", 64'(ok), 64'd1);
        chk_resp("hold", 8'hEF, 8'h00);

        // reset while the second byte is on the wire
        txq.delete();
        send_byte(8'h01);
        send_byte(8'h03);
        wait_req(ok);
        pulse_valid(1'b0, 40'h2D00190046);
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (txq.size() == 2) begin
                ok = 1;
                break;
            end
        end
        chk("rst_mid_reach_wait1", 64'(ok), 64'd1);
        chk("rst_mid_pre_busy", 64'(busy), 64'd1);
        chk("rst_mid_pre_byte", 64'(tx_byte), 64'h19);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_tx_byte", 64'(tx_byte), 64'd0);
        chk("rst_mid_tx_dv", 64'(tx_dv), 64'd0);
        chk("rst_mid_addr", 64'(sensor_addr), 64'd0);
        chk("rst_mid_req", 64'(sensor_req), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_mid_idle", 64'(busy), 64'd0);
        chk("rst_mid_no_more_tx", 64'(txq.size()), 64'd2);
        run_vec(vecs[0], "after_rst");

        chk("tx_byte_stable", 64'(stab_err), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_cmd_processor.md
Name: uart_cmd_processor

Overview:
- Sits between uart_rx and uart_tx in main and replaces the direct RX→TX loopback.
- Collects a 2-byte request (command, sensor address) from uart_rx and, if needed, requests one DHT11 frame from the sensor reader.
- Validates the frame checksum and sends a 2-byte response (code, data) through uart_tx using its DV/Done handshake.

Parameters:
- BYTE_TIMEOUT_CLKS, 5_000_000: max clocks between command byte and address byte (100 ms at 50 MHz).
- SENSOR_TIMEOUT_CLKS, 50_000_000: max clocks from o_Sensor_Req to i_Sensor_Valid (1 s).
- NUM_SENSORS, 32: valid addresses are 0..NUM_SENSORS-1.

Ports:
- i_Clock  in  1  system clock, 50 MHz.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Rx_DV  in  1  one-cycle pulse, byte valid from uart_rx.
- i_Rx_Byte  in  8  received byte.
- o_Tx_DV  out  1  one-cycle pulse to uart_tx.
- o_Tx_Byte  out  8  byte to uart_tx, held stable until i_Tx_Done.
- i_Tx_Active  in  1  uart_tx busy.
- i_Tx_Done  in  1  one-cycle pulse, uart_tx byte finished.
- o_Sensor_Req  out  1  one-cycle pulse, start a DHT11 read.
- o_Sensor_Addr  out  5  sensor index, valid from Req until Valid.
- i_Sensor_Valid  in  1  one-cycle pulse, read finished.
- i_Sensor_Err  in  1  sampled with Valid: no response from the sensor.
- i_Sensor_Data  in  40  sampled with Valid: {hum_int, hum_dec, temp_int, temp_dec, checksum}.
- o_Busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values: o_Tx_DV=0, o_Tx_Byte=0, o_Sensor_Req=0, o_Sensor_Addr=0, o_Busy=0. State goes to IDLE, counters are cleared, and any transaction in progress is discarded.
- All outputs are registered.
- States and transitions:
  - IDLE: on i_Rx_DV, latch cmd and go to GET_ADDR.
  - GET_ADDR: on i_Rx_DV, latch addr and go to CHECK. If the timeout counter reaches BYTE_TIMEOUT_CLKS-1, go back to IDLE with no response.
  - CHECK (1 cycle):
    - cmd > 0x02 → response {0xEF, 0x00}.
    - Otherwise addr ≥ NUM_SENSORS → response {0xDF, 0x00}.
    - Otherwise assert o_Sensor_Req for 1 cycle and go to SENSOR_WAIT.
    - The command check has priority over the address check.
  - SENSOR_WAIT: on i_Sensor_Valid, build the response. If SENSOR_TIMEOUT_CLKS elapse first, treat it as a sensor error.
  - SEND0 / WAIT0 / SEND1 / WAIT1: transmit the two response bytes, then return to IDLE.
- Checksum: ok when byte0+byte1+byte2+byte3 mod 256 == byte4. Error = i_Sensor_Err, timeout, or checksum mismatch.
- Response table:
  - cmd 0x00: error → {0x1F, 0x00}; ok → {0x07, 0x00}.
  - cmd 0x01: error → {0x1F, 0x00}; ok → {0x09, temp_int}.
  - cmd 0x02: error → {0x1F, 0x00}; ok → {0x08, hum_int}.
- TX handshake:
  - SEND: wait until i_Tx_Active=0, then load o_Tx_Byte and pulse o_Tx_DV for exactly 1 cycle.
  - WAIT: hold o_Tx_Byte and wait for i_Tx_Done.
  - No timeout on TX.
- i_Rx_DV in any state other than IDLE or GET_ADDR is dropped; it is not queued.
- An i_Sensor_Valid outside SENSOR_WAIT is ignored.
- Latency: CHECK→o_Tx_DV for an invalid request is 2 cycles when TX is idle. i_Sensor_Valid→o_Tx_DV is 2 cycles.

Test Plan:
- Bytes 0x01, 0x03; Valid with Data={0x2D,0x00,0x19,0x00,0x46}, Err=0 → o_Sensor_Addr=3, one Req pulse, TX sends 0x09 then 0x19, o_Busy returns to 0.
- Bytes 0x02, 0x00; Data={0x2D,0x00,0x19,0x00,0x47} (bad checksum) → TX 0x1F, 0x00.
- Bytes 0x05, 0x40 → no Req, TX 0xEF, 0x00 (command error wins). Bytes 0x00, 0x20 → TX 0xDF, 0x00.
- Byte 0x00 only, wait BYTE_TIMEOUT_CLKS (reduced to 100 in the bench) → return to IDLE with no TX. The next pair 0x00, 0x01 with valid data → TX 0x07, 0x00.
- Req issued, sensor silent for SENSOR_TIMEOUT_CLKS (bench 200) → TX 0x1F, 0x00. Extra Rx bytes during SENSOR_WAIT are ignored.
- i_Tx_Active held high 50 cycles before SEND0 → o_Tx_DV deferred until it falls. Assert i_Rst_n=0 during WAIT1 → outputs go to reset values at once, state IDLE.
